// File: rtl/div32s16_if.sv
// Operand/result handshake bundle for the 32/16 signed divider.
// The master side supplies operands and accepts results; the slave side is the divider.
interface div32s16_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div32s16_seq.sv
// Sequential signed 32/16 divider: restoring division on magnitudes, one quotient bit
// per cycle, followed by a single sign-fixup cycle that also detects quotient overflow.
module div32s16_seq (
    input  logic      clk,
    input  logic      rst_n,
    div32s16_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] dvd;      // dividend magnitude, shifted out MSB-first; collects quotient bits
    logic [16:0] dsr;      // divisor magnitude, 17 bits so 32768 is exact
    logic [15:0] rem;
    logic        sign_q, sign_r;
    logic [15:0] quo_r, rem_r;
    logic        dbz_r, ovf_r;

    logic        accept;
    logic        last_iter;
    logic [31:0] abs_dvd;
    logic [16:0] abs_dsr;
    logic [16:0] shifted;
    logic [15:0] diff;
    logic        borrow;
    logic [32:0] q_signed;
    logic [15:0] r_signed;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_iter = (cnt == 5'd31);

    assign abs_dvd = bus.dividend[31] ? (32'd0 - bus.dividend) : bus.dividend;
    assign abs_dsr = bus.divisor[15] ? (17'd0 - {1'b1, bus.divisor}) : {1'b0, bus.divisor};

    // Partial remainder is always below |divisor| <= 2^15, so the low 16 bits of the
    // difference are exact whenever no borrow occurs.
    assign shifted = {rem, dvd[31]};
    assign borrow  = (shifted < dsr);
    assign diff    = shifted[15:0] - dsr[15:0];

    // 33-bit signed quotient so a 2^31 magnitude survives negation.
    assign q_signed = sign_q ? (33'd0 - {1'b0, dvd}) : {1'b0, dvd};
    assign r_signed = sign_r ? (16'd0 - rem) : rem;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (bus.divisor == 16'd0) ? DONE : CALC;
            CALC: if (last_iter) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            quo_r  <= '0;
            rem_r  <= '0;
            dbz_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt    <= '0;
                    dvd    <= abs_dvd;
                    dsr    <= abs_dsr;
                    rem    <= '0;
                    sign_q <= bus.dividend[31] ^ bus.divisor[15];
                    sign_r <= bus.dividend[31];
                    ovf_r  <= 1'b0;
                    if (bus.divisor == 16'd0) begin
                        quo_r <= 16'hFFFF;
                        rem_r <= bus.dividend[15:0];
                        dbz_r <= 1'b1;
                    end else begin
                        dbz_r <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    dvd <= {dvd[30:0], ~borrow};
                    rem <= borrow ? shifted[15:0] : diff;
                end
                FIX: begin
                    quo_r <= q_signed[15:0];
                    rem_r <= r_signed;
                    ovf_r <= (q_signed[32:15] != {18{q_signed[15]}});
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_div32s16_seq.sv
// Directed-vector bench for div32s16_seq; expected values are hand-computed.
module tb_div32s16_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    div32s16_if bus();

    div32s16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one operation, then count edges after the accept edge until out_valid.
    // lat = -1 if the result never appears within the budget.
    task automatic do_op(input logic [31:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.dividend  = 32'h12345678;
        bus.divisor   = 16'h0000;
        bus.out_ready = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quotient !== 16'h0 ||
            bus.remainder !== 16'h0 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ov=%b ir=%b q=%h r=%h dbz=%b ovf=%b, want 0 1 0000 0000 0 0",
                     bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ignores_in_valid: ov=%b ir=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_op(32'h00000064, 16'h0007, lat);
        checks++;
        if (lat !== 33) begin
            failures++;
            $display("FAIL basic_latency: got %0d edges, want 33", lat);
        end
        checks++;
        if (bus.quotient !== 16'h000E || bus.remainder !== 16'h0002 ||
            bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: q=%h r=%h dbz=%b ovf=%b, want 000e 0002 0 0",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready_exclusive: in_ready=%b with out_valid, want 0", bus.in_ready);
        end
        release_result();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_complete: ov=%b ir=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    // dividend, divisor, quotient, remainder, overflow
    task automatic test_signed();
        logic [31:0] a [0:4];
        logic [15:0] b [0:4];
        logic [15:0] q [0:4];
        logic [15:0] r [0:4];
        logic        o [0:4];
        int lat;
        a[0] = 32'hFFFFFF9C; b[0] = 16'h0007; q[0] = 16'hFFF2; r[0] = 16'hFFFE; o[0] = 1'b0;
        a[1] = 32'h00000064; b[1] = 16'hFFF9; q[1] = 16'hFFF2; r[1] = 16'h0002; o[1] = 1'b0;
        a[2] = 32'h40000000; b[2] = 16'h8000; q[2] = 16'h8000; r[2] = 16'h0000; o[2] = 1'b0;
        a[3] = 32'h00010000; b[3] = 16'h0001; q[3] = 16'h0000; r[3] = 16'h0000; o[3] = 1'b1;
        a[4] = 32'h80000000; b[4] = 16'hFFFF; q[4] = 16'h0000; r[4] = 16'h0000; o[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_op(a[i], b[i], lat);
            checks++;
            if (lat !== 33 || bus.quotient !== q[i] || bus.remainder !== r[i] ||
                bus.overflow !== o[i] || bus.div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL signed_%0d (%h/%h): lat=%0d q=%h r=%h ovf=%b dbz=%b, want 33 %h %h %b 0",
                         i, a[i], b[i], lat, bus.quotient, bus.remainder, bus.overflow,
                         bus.div_by_zero, q[i], r[i], o[i]);
            end
            release_result();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(32'h12345678, 16'h0000, lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL div0_latency: got %0d edges, want 1", lat);
        end
        checks++;
        if (bus.quotient !== 16'hFFFF || bus.remainder !== 16'h5678 ||
            bus.div_by_zero !== 1'b1 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL div0_result: q=%h r=%h dbz=%b ovf=%b, want ffff 5678 1 0",
                     bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        release_result();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL div0_complete: in_ready=%b, want 1", bus.in_ready);
        end
    endtask

    // 1000 / -3 = -333 (0xFEB3) remainder 1, held under backpressure
    task automatic test_backpressure();
        int lat;
        int bad;
        do_op(32'h000003E8, 16'hFFFD, lat);
        checks++;
        if (lat !== 33 || bus.quotient !== 16'hFEB3 || bus.remainder !== 16'h0001 ||
            bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL bp_result: lat=%0d q=%h r=%h dbz=%b ovf=%b, want 33 feb3 0001 0 0",
                     lat, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 32'h0000_0005 + i;
            bus.divisor  = 16'h0000;
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 16'hFEB3 ||
                bus.remainder !== 16'h0001 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        end
        release_result();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: ov=%b ir=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_midcalc();
        int bad;
        int lat;
        @(negedge clk);
        bus.dividend = 32'h00000064;
        bus.divisor  = 16'h0007;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.quotient !== 16'h0 || bus.remainder !== 16'h0 ||
            bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL midcalc_reset: ov=%b q=%h r=%h dbz=%b ovf=%b, want 0 0000 0000 0 0",
                     bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL midcalc_no_stale: %0d cycles with result or not idle, want 0", bad);
        end
        do_op(32'h00000064, 16'h0007, lat);
        checks++;
        if (lat !== 33 || bus.quotient !== 16'h000E || bus.remainder !== 16'h0002) begin
            failures++;
            $display("FAIL post_reset_op: lat=%0d q=%h r=%h, want 33 000e 0002",
                     lat, bus.quotient, bus.remainder);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_backpressure();
        test_reset_midcalc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
